// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
//============================================================================
// Module  : uart_tx_scheduler_if
// Brief   : Request-side and serializer-side signals of the UART TX scheduler.
// Revision: 1.0
//============================================================================
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 err_lost;
  logic                 err_abort;

  // The scheduler is the slave; sources plus serializer form the master side.
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_data, tx_start, err_lost, err_abort
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_data, tx_start, err_lost, err_abort
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
//============================================================================
// Module  : uart_tx_scheduler
// Brief   : Round-robin packet arbiter feeding one start/busy UART serializer.
// Revision: 1.0
//============================================================================
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_GAP     = 1024
) (
  input  wire logic          CLK_50,
  input  wire logic          RESET,
  uart_tx_scheduler_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = $clog2(MAX_GAP + 1);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]         state_q,     state_d;
  logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [PTR_W-1:0]   gidx_q,      gidx_d;
  logic [NUM_REQ-1:0] grant_q,     grant_d;
  logic [7:0]         tx_data_q,   tx_data_d;
  logic               tx_start_q,  tx_start_d;
  logic               last_q,      last_d;
  logic               err_lost_q,  err_lost_d;
  logic               err_abort_q, err_abort_d;
  logic [GAP_W-1:0]   gap_q,       gap_d;
  logic [ACK_W-1:0]   ack_q,       ack_d;

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [7:0]         w_sel_data;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_xfer;
  logic               w_byte_done;

  function automatic logic [PTR_W-1:0] f_wrap(input int v);
    return PTR_W'(v % NUM_REQ);
  endfunction

  // Only the granted source is ever looked at once a packet is running.
  assign w_sel_valid = bus.req_valid[gidx_q];
  assign w_sel_last  = bus.req_last[gidx_q];
  assign w_sel_data  = bus.req_data[{gidx_q, 3'b000} +: 8];

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[f_wrap(int'(rr_ptr_q) + k)]) begin
        w_found = 1'b1;
        w_win   = f_wrap(int'(rr_ptr_q) + k);
      end
    end
  end

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      last_q      <= 1'b0;
      err_lost_q  <= 1'b0;
      err_abort_q <= 1'b0;
      gap_q       <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      last_q      <= last_d;
      err_lost_q  <= err_lost_d;
      err_abort_q <= err_abort_d;
      gap_q       <= gap_d;
      ack_q       <= ack_d;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    last_d      = last_q;
    err_lost_d  = err_lost_q;
    err_abort_d = err_abort_q;
    gap_d       = gap_q;
    ack_d       = ack_q;
    w_byte_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          grant_d  = ONE_HOT_0 << w_win;
          gidx_d   = w_win;
          rr_ptr_d = f_wrap(int'(w_win) + 1);
          gap_d    = '0;
          state_d  = S_SEND;
        end
      end

      S_SEND: begin
        if (w_xfer) begin
          tx_data_d  = w_sel_data;
          tx_start_d = 1'b1;
          last_d     = w_sel_last;
          gap_d      = '0;
          ack_d      = '0;
          state_d    = S_WAIT_HI;
        end else if (!w_sel_valid) begin
          // A source that goes silent too long forfeits the rest of its packet.
          if (gap_q >= GAP_W'(MAX_GAP - 1)) begin
            err_abort_d = 1'b1;
            grant_d     = '0;
            state_d     = S_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      S_WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_LO;
        end else if (ack_q >= ACK_W'(ACK_TIMEOUT - 1)) begin
          err_lost_d  = 1'b1;
          w_byte_done = 1'b1;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end

      S_WAIT_LO: begin
        if (!bus.tx_busy) begin
          w_byte_done = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A lost acknowledge is handled exactly like a completed frame.
    if (w_byte_done) begin
      if (last_q) begin
        grant_d = '0;
        state_d = S_IDLE;
      end else begin
        state_d = S_SEND;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Output logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_ready = '0;
    if ((state_q == S_SEND) && !bus.tx_busy) begin
      w_ready = grant_q & bus.req_valid;
    end
  end

  assign w_xfer        = |w_ready;
  assign bus.req_ready = w_ready;
  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.err_lost  = err_lost_q;
  assign bus.err_abort = err_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
//============================================================================
// Module  : tb_uart_tx_scheduler
// Brief   : Directed self-checking bench with source queues and a busy model.
// Revision: 1.0
//============================================================================
module tb_uart_tx_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int BUSY_LEN = 10;

  logic clk;
  logic rst;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .ACK_TIMEOUT(16),
    .MAX_GAP    (1024)
  ) dut (
    .CLK_50(clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] src_q [NUM_REQ][$];
  logic [7:0] data_log [$];
  logic [3:0] gnt_log [$];
  int         stray_ready = 0;
  int         busy_cnt    = 0;
  logic       busy_force  = 1'b0;
  logic       ser_respond = 1'b1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() != 0) begin
        bus.req_valid[i]      = 1'b1;
        bus.req_data[8*i +: 8] = src_q[i][0][7:0];
        bus.req_last[i]       = src_q[i][0][8];
      end else begin
        bus.req_valid[i]      = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]       = 1'b0;
      end
    end
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: observe at negedge, then update sources and serializer after the edge.
  task automatic tick();
    logic [NUM_REQ-1:0] xfer;
    logic               start_seen;
    @(negedge clk);
    xfer       = bus.req_valid & bus.req_ready;
    start_seen = bus.tx_start;
    if (start_seen) begin
      data_log.push_back(bus.tx_data);
      gnt_log.push_back(bus.grant);
    end
    if (((bus.req_ready & ~bus.grant) != '0) || ($countones(bus.req_ready) > 1)) stray_ready++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer[i] && (src_q[i].size() != 0)) void'(src_q[i].pop_front());
    end
    if (start_seen && ser_respond) busy_cnt = BUSY_LEN;
    else if (busy_cnt > 0)         busy_cnt--;
    bus.tx_busy = busy_force || (busy_cnt > 0);
    drive_sources();
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!(srcs_empty() && (bus.grant == '0) && !bus.tx_busy) && (n < max_cycles)) begin
      tick();
      n++;
    end
    check_value({tag, "_done"}, 32'(n < max_cycles), 32'd1);
  endtask

  task automatic check_logs(input string tag, input int n,
                            input logic [7:0] ed [8], input logic [3:0] eg [8]);
    check_value({tag, "_count"}, data_log.size(), n);
    for (int i = 0; i < n; i++) begin
      check_value($sformatf("%s_data%0d", tag, i),
                  (i < data_log.size()) ? 32'(data_log[i]) : 32'hFFFF_FFFF, 32'(ed[i]));
      check_value($sformatf("%s_grant%0d", tag, i),
                  (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, 32'(eg[i]));
    end
  endtask

  task automatic clear_logs();
    data_log.delete();
    gnt_log.delete();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    busy_force  = 1'b0;
    ser_respond = 1'b1;
    busy_cnt    = 0;
    bus.tx_busy = 1'b0;
    drive_sources();
    tick();
    tick();
    check_value({tag, "_grant"},     bus.grant,     '0);
    check_value({tag, "_ready"},     bus.req_ready, '0);
    check_value({tag, "_start"},     bus.tx_start,  0);
    check_value({tag, "_data"},      bus.tx_data,   8'h00);
    check_value({tag, "_err_lost"},  bus.err_lost,  0);
    check_value({tag, "_err_abort"}, bus.err_abort, 0);
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_busy   = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst");

    // 1: single packet "uLab" from source 0, with latency checks.
    src_q[0].push_back({1'b0, 8'h75});
    src_q[0].push_back({1'b0, 8'h4C});
    src_q[0].push_back({1'b0, 8'h61});
    src_q[0].push_back({1'b1, 8'h62});
    drive_sources();
    check_value("t1_grant_lat0", bus.grant, 4'b0000);
    tick();
    check_value("t1_grant_lat1", bus.grant, 4'b0001);
    check_value("t1_ready", bus.req_ready, 4'b0001);
    tick();
    check_value("t1_start_pulse", bus.tx_start, 1);
    check_value("t1_first_data", bus.tx_data, 8'h75);
    tick();
    check_value("t1_start_single", bus.tx_start, 0);
    run_until_idle("t1", 200);
    check_logs("t1", 4, '{8'h75, 8'h4C, 8'h61, 8'h62, 8'h0, 8'h0, 8'h0, 8'h0},
                        '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0});
    check_value("t1_grant_end", bus.grant, 4'b0000);

    // 2: round-robin after reset, then fairness with rr_ptr past source 2.
    do_reset("t2rst");
    src_q[1].push_back({1'b0, 8'hA1});
    src_q[1].push_back({1'b1, 8'hA2});
    src_q[2].push_back({1'b1, 8'hB1});
    drive_sources();
    run_until_idle("t2a", 300);
    check_logs("t2a", 3, '{8'hA1, 8'hA2, 8'hB1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                         '{4'h2, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    clear_logs();
    src_q[1].push_back({1'b1, 8'hC1});
    src_q[3].push_back({1'b1, 8'hD1});
    drive_sources();
    run_until_idle("t2b", 300);
    check_logs("t2b", 2, '{8'hD1, 8'hC1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                         '{4'h8, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});

    // 3: serializer never acknowledges.
    do_reset("t3rst");
    ser_respond = 1'b0;
    src_q[0].push_back({1'b0, 8'h11});
    src_q[0].push_back({1'b1, 8'h22});
    drive_sources();
    n = 0;
    while ((data_log.size() == 0) && (n < 20)) begin
      tick();
      n++;
    end
    check_value("t3_first_start", data_log.size(), 1);
    repeat (10) tick();
    check_value("t3_lost_early", bus.err_lost, 0);
    run_until_idle("t3", 200);
    check_value("t3_err_lost", bus.err_lost, 1);
    check_value("t3_err_abort", bus.err_abort, 0);
    check_logs("t3", 2, '{8'h11, 8'h22, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                        '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});

    // 6: reset in WAIT_LO clears everything, including the sticky err_lost from above.
    clear_logs();
    ser_respond = 1'b1;
    src_q[0].push_back({1'b0, 8'h66});
    src_q[0].push_back({1'b1, 8'h77});
    drive_sources();
    n = 0;
    while (!((data_log.size() == 1) && bus.tx_busy) && (n < 20)) begin
      tick();
      n++;
    end
    tick();
    check_value("t6_in_frame", bus.tx_busy, 1);
    check_value("t6_lost_sticky", bus.err_lost, 1);
    check_value("t6_grant_pre", bus.grant, 4'b0001);
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    drive_sources();
    tick();
    check_value("t6_grant", bus.grant, 4'b0000);
    check_value("t6_ready", bus.req_ready, 4'b0000);
    check_value("t6_start", bus.tx_start, 0);
    check_value("t6_data", bus.tx_data, 8'h00);
    check_value("t6_err_lost", bus.err_lost, 0);
    check_value("t6_err_abort", bus.err_abort, 0);
    rst = 1'b0;
    n = 0;
    while (bus.tx_busy && (n < 20)) begin
      tick();
      n++;
    end
    check_value("t6_frame_drained", bus.tx_busy, 0);
    check_value("t6_no_more_start", data_log.size(), 1);

    // 4: source 0 stalls mid-packet past MAX_GAP; source 2 is then served.
    do_reset("t4rst");
    src_q[0].push_back({1'b0, 8'h31});
    src_q[2].push_back({1'b1, 8'h41});
    drive_sources();
    n = 0;
    while ((data_log.size() == 0) && (n < 20)) begin
      tick();
      n++;
    end
    repeat (1000) tick();
    check_value("t4_abort_early", bus.err_abort, 0);
    check_value("t4_grant_held", bus.grant, 4'b0001);
    check_value("t4_src2_ready", bus.req_ready[2], 0);
    run_until_idle("t4", 300);
    check_value("t4_err_abort", bus.err_abort, 1);
    check_value("t4_err_lost", bus.err_lost, 0);
    check_logs("t4", 2, '{8'h31, 8'h41, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                        '{4'h1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});

    // 5: serializer busy at grant time blocks the transfer.
    do_reset("t5rst");
    busy_force  = 1'b1;
    bus.tx_busy = 1'b1;
    src_q[3].push_back({1'b1, 8'h5A});
    drive_sources();
    tick();
    check_value("t5_grant", bus.grant, 4'b1000);
    repeat (4) tick();
    check_value("t5_ready_blocked", bus.req_ready, 4'b0000);
    check_value("t5_no_start", data_log.size(), 0);
    busy_force  = 1'b0;
    bus.tx_busy = 1'b0;
    #1;
    check_value("t5_ready_released", bus.req_ready, 4'b1000);
    run_until_idle("t5", 100);
    check_logs("t5", 1, '{8'h5A, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                        '{4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});

    check_value("stray_ready", stray_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
